// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch/data request buses and SRAM macro bus shared by the arbiter
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;
  logic              inst_req;
  logic [BE_W-1:0]   inst_we;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata;
  logic              inst_gnt;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic [BE_W-1:0]   data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_gnt;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;
  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  // pipeline units plus the SRAM macro
  modport master (
    output inst_req, inst_we, inst_addr, inst_wdata,
    output data_req, data_we, data_addr, data_wdata,
    output sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
  // the arbiter
  modport slave (
    input  inst_req, inst_we, inst_addr, inst_wdata,
    input  data_req, data_we, data_addr, data_wdata,
    input  sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between fetch and data with fetch anti-starvation
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  sram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {NONE, INST, DATA} owner_t;
  owner_t            rd_owner, owner_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [DATA_W-1:0] inst_hold, data_hold;
  logic              force_inst, inst_gnt, data_gnt, inst_rvalid, data_rvalid;
  // grant decision, starvation counter update and next response owner
  always_comb begin
    force_inst = bus.inst_req && (starve_cnt == 4'(STARVE_MAX));
    data_gnt   = bus.data_req && !force_inst;
    inst_gnt   = bus.inst_req && !data_gnt;
    starve_nxt = (bus.inst_req && !inst_gnt) ?
                 ((starve_cnt == 4'(STARVE_MAX)) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
    owner_nxt  = (inst_gnt && bus.inst_we == '0) ? INST :
                 (data_gnt && bus.data_we == '0) ? DATA : NONE;
  end
  // state registers; reset drops any read still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner   <= NONE;
      starve_cnt <= 4'd0;
    end else begin
      rd_owner   <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  // keep the last word returned to each requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      inst_hold <= inst_rvalid ? bus.sram_rdata : inst_hold;
      data_hold <= data_rvalid ? bus.sram_rdata : data_hold;
    end
  end
  assign inst_rvalid     = rd_owner == INST;
  assign data_rvalid     = rd_owner == DATA;
  assign bus.inst_gnt    = inst_gnt;
  assign bus.data_gnt    = data_gnt;
  assign bus.inst_rvalid = inst_rvalid;
  assign bus.data_rvalid = data_rvalid;
  assign bus.inst_rdata  = inst_rvalid ? bus.sram_rdata : inst_hold;
  assign bus.data_rdata  = data_rvalid ? bus.sram_rdata : data_hold;
  assign bus.sram_en     = inst_gnt | data_gnt;
  assign bus.sram_we     = data_gnt ? bus.data_we    : inst_gnt ? bus.inst_we    : '0;
  assign bus.sram_addr   = data_gnt ? bus.data_addr  : inst_gnt ? bus.inst_addr  : '0;
  assign bus.sram_wdata  = data_gnt ? bus.data_wdata : inst_gnt ? bus.inst_wdata : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed plus random checks of the SRAM arbiter against a cycle model
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SM = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fails = 0;
  int streak = 0;
  int pend = 0;
  logic [DW-1:0] pend_val = '0;
  logic [DW-1:0] ihold = '0;
  logic [DW-1:0] dhold = '0;
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // SRAM stand-in: a read of address A returns A+1 on the next cycle
  always @(posedge clk) begin
    if (bus.sram_en && bus.sram_we == '0) bus.sram_rdata <= DW'(bus.sram_addr + 1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic ir, input logic [BW-1:0] iwe, input logic [AW-1:0] ia,
                       input logic [DW-1:0] iwd, input logic dr, input logic [BW-1:0] dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    bus.inst_req = ir; bus.inst_we = iwe; bus.inst_addr = ia; bus.inst_wdata = iwd;
    bus.data_req = dr; bus.data_we = dwe; bus.data_addr = da; bus.data_wdata = dwd;
  endtask
  // one clock of stimulus: checks at the falling edge, model advances at the rising edge
  task automatic cycle(input logic ir, input logic [BW-1:0] iwe, input logic [AW-1:0] ia,
                       input logic [DW-1:0] iwd, input logic dr, input logic [BW-1:0] dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    logic gi, gd;
    logic [BW-1:0] ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    drive(ir, iwe, ia, iwd, dr, dwe, da, dwd);
    gd = dr && !(ir && streak >= SM);
    gi = ir && !gd;
    ew = gd ? dwe : gi ? iwe : '0;
    ea = gd ? da : gi ? ia : '0;
    ed = gd ? dwd : gi ? iwd : '0;
    if (pend == 1) ihold = pend_val;
    if (pend == 2) dhold = pend_val;
    @(negedge clk);
    chk("inst_gnt", 64'(bus.inst_gnt), 64'(gi));
    chk("data_gnt", 64'(bus.data_gnt), 64'(gd));
    chk("sram_en", 64'(bus.sram_en), 64'(gi | gd));
    chk("sram_we", 64'(bus.sram_we), 64'(ew));
    chk("sram_addr", 64'(bus.sram_addr), 64'(ea));
    chk("sram_wdata", 64'(bus.sram_wdata), 64'(ed));
    chk("inst_rvalid", 64'(bus.inst_rvalid), 64'(pend == 1));
    chk("data_rvalid", 64'(bus.data_rvalid), 64'(pend == 2));
    chk("inst_rdata", 64'(bus.inst_rdata), 64'(ihold));
    chk("data_rdata", 64'(bus.data_rdata), 64'(dhold));
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(streak));
    @(posedge clk);
    streak   = (ir && !gi) ? streak + 1 : 0;
    pend     = (gi && iwe == '0) ? 1 : (gd && dwe == '0) ? 2 : 0;
    pend_val = DW'(ea + 1);
    #1;
  endtask
  initial begin
    bus.sram_rdata = '0;
    drive(0, '0, '0, '0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_rvalid", 64'(bus.inst_rvalid), 64'd0);
    chk("rst_data_rvalid", 64'(bus.data_rvalid), 64'd0);
    chk("rst_inst_rdata", 64'(bus.inst_rdata), 64'd0);
    chk("rst_data_rdata", 64'(bus.data_rdata), 64'd0);
    chk("rst_sram_en", 64'(bus.sram_en), 64'd0);
    reset = 1'b0;
    // reset in the middle of a read stream: response is dropped at once
    cycle(0, '0, '0, '0, 1, '0, 32'h10, '0);
    cycle(0, '0, '0, '0, 1, '0, 32'h20, '0);
    chk("pre_rst_data_rvalid", 64'(bus.data_rvalid), 64'd1);
    reset = 1'b1;
    drive(0, '0, '0, '0, 0, '0, '0, '0);
    #1;
    chk("mid_rst_data_rvalid", 64'(bus.data_rvalid), 64'd0);
    chk("mid_rst_data_rdata", 64'(bus.data_rdata), 64'd0);
    chk("mid_rst_inst_rdata", 64'(bus.inst_rdata), 64'd0);
    pend = 0; streak = 0; ihold = '0; dhold = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) cycle(0, '0, '0, '0, 0, '0, '0, '0);
    // solo fetch at full rate
    repeat (4) cycle(1, '0, 32'h1c000000, '0, 0, '0, '0, '0);
    cycle(0, '0, '0, '0, 0, '0, '0, '0);
    chk("solo_inst_rdata", 64'(bus.inst_rdata), 64'h1c000001);
    // contention: D,D,D,I repeating
    repeat (10) cycle(1, '0, 32'h1c000100, '0, 1, '0, 32'h200, '0);
    cycle(0, '0, '0, '0, 0, '0, '0, '0);
    // write routing: read 0x12345678, then a byte-masked write leaves it held
    cycle(0, '0, '0, '0, 1, '0, 32'h12345677, '0);
    cycle(0, '0, '0, '0, 1, 4'b0011, 32'h100, 32'hdeadbeef);
    cycle(0, '0, '0, '0, 0, '0, '0, '0);
    chk("write_keeps_data_rdata", 64'(bus.data_rdata), 64'h12345678);
    // data idle while fetch reads: data word held
    repeat (5) cycle(1, '0, 32'h400, '0, 0, '0, '0, '0);
    chk("hold_data_rdata", 64'(bus.data_rdata), 64'h12345678);
    // idle
    repeat (2) cycle(0, '0, '0, '0, 0, '0, '0, '0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0,
            AW'($urandom), DW'($urandom),
            $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0,
            AW'($urandom), DW'($urandom));
    end
    cycle(0, '0, '0, '0, 0, '0, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the fetch stage (instruction requester) and the memory stage (data requester).
- Grants at most one requester per cycle. Data has priority, with an anti-starvation override for fetch.
- Routes each read response back to the requester that issued it.
- Sits between the IF/MEM pipeline units and the SRAM macro; replaces the separate inst/data SRAM ports when a unified memory is configured.

Parameters:
- ADDR_W, 32, SRAM address width in bits.
- DATA_W, 32, SRAM data width in bits. Must be a multiple of 8; the byte-enable width is DATA_W/8.
- STARVE_MAX, 3, number of consecutive denied fetch-request cycles after which fetch wins over data. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch access request
- inst_we  in  DATA_W/8  fetch byte write enables; all-zero means read
- inst_addr  in  ADDR_W  fetch address
- inst_wdata  in  DATA_W  fetch write data
- inst_gnt  out  1  fetch granted this cycle (combinational)
- inst_rvalid  out  1  fetch read data valid (one-cycle pulse)
- inst_rdata  out  DATA_W  fetch read data
- data_req, data_we, data_addr, data_wdata  in  as inst_*  data-side request
- data_gnt  out  1  data granted this cycle (combinational)
- data_rvalid  out  1  data read data valid (one-cycle pulse)
- data_rdata  out  DATA_W  data read data
- sram_en  out  1  SRAM enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after an enabled read

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Grant (combinational, same cycle as request):
  - force_inst = inst_req && (starve_cnt == STARVE_MAX).
  - data_gnt = data_req && !force_inst.
  - inst_gnt = inst_req && !data_gnt.
  - inst_gnt and data_gnt are never both 1.
- SRAM mux: sram_en = inst_gnt | data_gnt. sram_we/addr/wdata come from the granted requester. With no grant, sram_en=0 and sram_we, sram_addr, sram_wdata are all 0.
- Request hold: a denied requester keeps req and its operands stable. The arbiter stores no pending request.
- starve_cnt (4-bit register):
  - Increments when inst_req && !inst_gnt, saturating at STARVE_MAX.
  - Cleared to 0 when inst_gnt=1 or inst_req=0.
- Response owner register, rd_owner ∈ {NONE, INST, DATA}:
  - Next value is INST if inst_gnt && inst_we==0.
  - DATA if data_gnt && data_we==0.
  - Otherwise NONE.
- Response outputs:
  - inst_rvalid = (rd_owner==INST); data_rvalid = (rd_owner==DATA). Read latency is exactly 1 cycle after grant.
  - Writes (any we bit set) produce no rvalid.
- Read data hold:
  - inst_rdata = inst_rvalid ? sram_rdata : inst_hold. inst_hold captures sram_rdata on every inst_rvalid cycle.
  - data_rdata and data_hold follow the same rule with data_rvalid.
  - The last returned word therefore stays stable until the next read by the same requester.
- Back-to-back: one grant per cycle with full throughput. A read response in cycle N+1 coexists with a new grant in cycle N+1.
- Reset (asynchronous):
  - starve_cnt=0, rd_owner=NONE, inst_hold=0, data_hold=0.
  - All outputs: inst_rvalid=0, data_rvalid=0, inst_rdata=0, data_rdata=0.
  - Grants and sram_* follow the combinational rules; under reset the pipeline holds req low, so they read 0.
- Reset mid-operation: a read granted in the cycle before reset assertion produces no rvalid. No response is generated after reset deasserts.
- Simultaneous requests:
  - Data wins unless force_inst.
  - When force_inst: fetch is granted, starve_cnt clears, data is denied for that cycle. Data is never denied two cycles in a row by starvation.

Test Plan:
- Reset: assert reset mid-cycle with data_req read granted the cycle before -> all rvalid=0 and rdata=0 immediately; no rvalid after release.
- Solo fetch: inst_req=1, inst_we=0, inst_addr=0x1c000000 each cycle, SRAM model returns addr+1 -> inst_gnt=1 every cycle; inst_rvalid=1 one cycle later with inst_rdata=0x1c000001; pipelined at full rate.
- Contention: both requesters active continuously, STARVE_MAX=3 -> grant pattern D,D,D,I,D,D,D,I. Verify starve_cnt 0,1,2,3,0 and that each rvalid goes to the correct requester with the correct data.
- Write routing: data_req with data_we=4'b0011, addr 0x100, wdata 0xdeadbeef -> sram_we=4'b0011, sram_wdata=0xdeadbeef; no data_rvalid the next cycle; data_rdata still holds the previous read value.
- Hold: data read returns 0x12345678, then data idle for 5 cycles while fetch reads -> data_rdata stays 0x12345678 and data_rvalid=0.
- Idle: no requests -> sram_en=0; sram_we, sram_addr, sram_wdata all 0; both gnt=0.
